// File: rtl/uart_tx_pkg.sv
// Shared encodings for the UART TX datapath: output-mux selects and the
// frame sequencer state codes.
package uart_tx_pkg;

   localparam logic [1:0] MUX_START  = 2'b00;
   localparam logic [1:0] MUX_SERIAL = 2'b01;
   localparam logic [1:0] MUX_PARITY = 2'b10;
   localparam logic [1:0] MUX_STOP   = 2'b11;

   // Three bits leave codes 5..7 unused; those fall back to IDLE.
   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_START  = 3'd1;
   localparam state_t ST_DATA   = 3'd2;
   localparam state_t ST_PARITY = 3'd3;
   localparam state_t ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_tx_bit_cnt.sv
// Data-bit counter: clear wins over enable, terminal flag at DATA_WIDTH-1.
// Returns to zero after the terminal count, so it never exceeds DATA_WIDTH-1.
module uart_tx_bit_cnt #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
   input  logic CLK,
   input  logic RST,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   localparam logic [CNT_WIDTH-1:0] TC_VAL = CNT_WIDTH'(DATA_WIDTH - 1);

   logic [CNT_WIDTH-1:0] r_cnt;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         r_cnt <= '0;
      else if (i_clr)
         r_cnt <= '0;
      else if (i_en)
         r_cnt <= (r_cnt == TC_VAL) ? '0 : r_cnt + 1'b1;
   end

   assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: start, DATA_WIDTH data bits LSB first,
// optional parity, stop. One clock cycle per bit time.
module uart_tx_ctrl
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       data_valid,
   input  logic       par_en,
   input  logic       par_typ,
   output logic       ser_load,
   output logic       ser_en,
   output logic       par_typ_q,
   output logic [1:0] mux_sel,
   output logic       busy
);

   state_t r_state;
   state_t w_next;
   logic   r_ser_load;
   logic   r_par_en;
   logic   r_par_typ;
   logic   w_accept;
   logic   w_tc;

   // New characters are taken only while idle or on the stop bit.
   assign w_accept = ((r_state == ST_IDLE) || (r_state == ST_STOP)) && data_valid;

   uart_tx_bit_cnt #(
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
   ) u_bit_cnt (
      .CLK   (CLK),
      .RST   (RST),
      .i_clr (r_state == ST_START),
      .i_en  (r_state == ST_DATA),
      .o_tc  (w_tc)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state    <= ST_IDLE;
         r_ser_load <= 1'b0;
         r_par_en   <= 1'b0;
         r_par_typ  <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_ser_load <= w_accept;
         if (w_accept) begin
            r_par_en  <= par_en;
            r_par_typ <= par_typ;
         end
      end
   end

   always_comb begin
      w_next = ST_IDLE;
      case (r_state)
         ST_IDLE:   w_next = data_valid ? ST_START : ST_IDLE;
         ST_START:  w_next = ST_DATA;
         ST_DATA:   w_next = w_tc ? (r_par_en ? ST_PARITY : ST_STOP) : ST_DATA;
         ST_PARITY: w_next = ST_STOP;
         ST_STOP:   w_next = data_valid ? ST_START : ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      mux_sel = MUX_STOP;
      busy    = 1'b0;
      ser_en  = 1'b0;
      case (r_state)
         ST_START: begin
            mux_sel = MUX_START;
            busy    = 1'b1;
         end
         ST_DATA: begin
            mux_sel = MUX_SERIAL;
            busy    = 1'b1;
            ser_en  = 1'b1;
         end
         ST_PARITY: begin
            mux_sel = MUX_PARITY;
            busy    = 1'b1;
         end
         ST_STOP: begin
            mux_sel = MUX_STOP;
            busy    = 1'b1;
         end
         default: begin
            mux_sel = MUX_STOP;
            busy    = 1'b0;
         end
      endcase
   end

   assign ser_load  = r_ser_load;
   assign par_typ_q = r_par_typ;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: per-cycle vector table fed through a
// scoreboard queue, plus hand-written reset sequences.
module tb_uart_tx_ctrl;

   localparam int DW = 8;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       data_valid = 1'b0;
   logic       par_en = 1'b0;
   logic       par_typ = 1'b0;
   logic       ser_load;
   logic       ser_en;
   logic       par_typ_q;
   logic [1:0] mux_sel;
   logic       busy;

   uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .data_valid (data_valid),
      .par_en     (par_en),
      .par_typ    (par_typ),
      .ser_load   (ser_load),
      .ser_en     (ser_en),
      .par_typ_q  (par_typ_q),
      .mux_sel    (mux_sel),
      .busy       (busy)
   );

   always #5 CLK = ~CLK;

   // Expected outputs packed as {mux_sel, busy, ser_en, ser_load, par_typ_q}.
   typedef struct {
      logic       dv;
      logic       pe;
      logic       pt;
      logic [5:0] exp;
      string      name;
   } vec_t;

   vec_t       vecs[$];
   logic [5:0] sb_q[$];
   int         n_vec = 0;
   int         n_err = 0;

   function automatic logic [5:0] outs();
      return {mux_sel, busy, ser_en, ser_load, par_typ_q};
   endfunction

   task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got mux=%b busy=%b sen=%b sload=%b ptq=%b, want mux=%b busy=%b sen=%b sload=%b ptq=%b",
                  name, act[5:4], act[3], act[2], act[1], act[0],
                  exp[5:4], exp[3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic add(input logic dv, pe, pt, input logic [1:0] m,
                      input logic b, sen, sl, ptq, input string name);
      vec_t v;
      v.dv = dv; v.pe = pe; v.pt = pt;
      v.exp = {m, b, sen, sl, ptq};
      v.name = name;
      vecs.push_back(v);
   endtask

   // One frame accepted on the first vector. Inputs during the frame use
   // pe_mid and an inverted par_typ, which must both be ignored. With hold the
   // next frame's accept vector follows the stop vector directly.
   task automatic add_frame(input logic pe, pt, pe_mid, hold, input string tag);
      add(1'b1, pe, pt, 2'b00, 1, 0, 1, pt, {tag, "_start"});
      for (int i = 0; i < DW; i++)
         add(hold, (i == 0) ? pe : pe_mid, ~pt, 2'b01, 1, 1, 0, pt, $sformatf("%s_data%0d", tag, i));
      if (pe)
         add(hold, pe_mid, ~pt, 2'b10, 1, 0, 0, pt, {tag, "_parity"});
      add(hold, pe_mid, ~pt, 2'b11, 1, 0, 0, pt, {tag, "_stop"});
      if (!hold)
         add(1'b0, pe_mid, ~pt, 2'b11, 0, 0, 0, pt, {tag, "_idle"});
   endtask

   initial begin
      add_frame(1'b0, 1'b0, 1'b0, 1'b0, "nopar");
      add(1'b0, 1'b0, 1'b0, 2'b11, 0, 0, 0, 1'b0, "idle_gap");
      add_frame(1'b1, 1'b1, 1'b1, 1'b0, "oddpar");
      add_frame(1'b1, 1'b0, 1'b0, 1'b0, "cfgchg");
      add_frame(1'b0, 1'b1, 1'b0, 1'b1, "b2b_a");
      add_frame(1'b0, 1'b0, 1'b0, 1'b0, "b2b_b");

      // Reset state, asynchronously asserted from time zero.
      #2;
      chk("reset_state", outs(), {2'b11, 1'b0, 1'b0, 1'b0, 1'b0});
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);

      foreach (vecs[i]) begin
         data_valid = vecs[i].dv;
         par_en     = vecs[i].pe;
         par_typ    = vecs[i].pt;
         sb_q.push_back(vecs[i].exp);
         @(posedge CLK);
         #1;
         if (sb_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL %s: scoreboard empty", vecs[i].name);
         end else begin
            chk(vecs[i].name, outs(), sb_q.pop_front());
         end
         @(negedge CLK);
      end

      // Reset mid-DATA: three data cycles, then asynchronous abort.
      data_valid = 1'b1; par_en = 1'b1; par_typ = 1'b1;
      @(posedge CLK); #1;
      @(negedge CLK); data_valid = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_pre_data", outs(), {2'b01, 1'b1, 1'b1, 1'b0, 1'b1});
      @(negedge CLK);
      #2 RST = 1'b0;
      #1;
      chk("rst_async", outs(), {2'b11, 1'b0, 1'b0, 1'b0, 1'b0});
      @(negedge CLK);
      RST = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge CLK); #1;
         chk($sformatf("rst_stay_idle%0d", c), outs(), {2'b11, 1'b0, 1'b0, 1'b0, 1'b0});
      end

      // data_valid already high when reset releases: first edge accepts.
      @(negedge CLK);
      RST = 1'b0; data_valid = 1'b1; par_en = 1'b0; par_typ = 1'b1;
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK); #1;
      chk("rel_accept", outs(), {2'b00, 1'b1, 1'b0, 1'b1, 1'b1});
      @(negedge CLK); data_valid = 1'b0;
      @(posedge CLK); #1;
      chk("rel_data0", outs(), {2'b01, 1'b1, 1'b1, 1'b0, 1'b1});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Frame sequencer for the UART transmitter.
- Drives the 2-bit output-mux select, the serializer shift/load enables and the busy flag so that one character is sent as start, DATA_WIDTH data bits (LSB first), optional parity, then stop.
- Sits in the UART TX top between the register-file/FIFO side (data_valid handshake) and the serializer, parity calculator and output mux.
- Runs at the UART TX clock; one clock cycle equals one bit time.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (2..16).
- CNT_WIDTH, $clog2(DATA_WIDTH), width of the internal data-bit counter.

Ports:
- CLK  input  1  TX bit clock (one bit period per cycle).
- RST  input  1  asynchronous active-low reset.
- data_valid  input  1  a character is available on the parallel bus; sampled only when the block is ready to accept.
- par_en  input  1  parity enable; captured at frame acceptance.
- par_typ  input  1  0 = even, 1 = odd; captured at frame acceptance.
- ser_load  output  1  one-cycle pulse; serializer and parity calculator capture the parallel data.
- ser_en  output  1  serializer shifts one bit this cycle.
- par_typ_q  output  1  latched parity type for the parity calculator.
- mux_sel  output  2  00 start, 01 serial data, 10 parity, 11 stop/idle.
- busy  output  1  frame in progress.

Behaviour:
- Reset (RST low, asynchronous):
  - state = IDLE, bit counter = 0, latched par_en/par_typ = 0.
  - mux_sel = 11, busy = 0, ser_en = 0, ser_load = 0, par_typ_q = 0.
- All outputs except ser_load are Moore-decoded from the registered state.
- ser_load is the registered acceptance strobe.
- States: IDLE, START, DATA, PARITY, STOP.
- Acceptance:
  - Occurs when state is IDLE or STOP and data_valid = 1 at the rising edge.
  - On that edge: ser_load = 1 for the following cycle; par_en and par_typ are latched; next state = START.
- IDLE: mux_sel = 11, busy = 0. data_valid = 0 -> stay.
- START: mux_sel = 00, busy = 1. Counter cleared to 0. Next state = DATA unconditionally.
- DATA:
  - mux_sel = 01, ser_en = 1, busy = 1.
  - Counter increments every cycle.
  - When counter = DATA_WIDTH-1: next state = PARITY if latched par_en = 1, else STOP.
  - Exactly DATA_WIDTH cycles are spent in DATA.
- PARITY: mux_sel = 10, busy = 1. Next state = STOP.
- STOP:
  - mux_sel = 11, busy = 1.
  - data_valid = 1 -> accept and go to START (back-to-back frames, no idle gap).
  - data_valid = 0 -> go to IDLE.
- Frame length from the first START cycle to the last STOP cycle: DATA_WIDTH+2 cycles without parity, DATA_WIDTH+3 with parity.
- The latency from the accepting edge to the first start bit on mux_sel is 1 cycle.
- Changes to par_en, par_typ or data_valid during START, DATA or PARITY are ignored. The latched values hold for the whole frame.
- par_typ_q is held from acceptance until the next acceptance.
- Counter is CNT_WIDTH bits wide, never exceeds DATA_WIDTH-1, and has no wrap-around in normal operation.
- An illegal state encoding recovers to IDLE on the next edge with outputs at idle values.
- Reset asserted mid-frame:
  - Immediate return to reset values; the line goes to 11 (idle high).
  - The frame is aborted, not resumed.
  - After release, data_valid is required to start again.
- When data_valid and reset release coincide, the first edge after release may accept.

Decomposition:
- Shared package uart_tx_pkg: mux_sel encodings (MUX_START = 00, MUX_SERIAL = 01, MUX_PARITY = 10, MUX_STOP = 11) and the state encoding constants. The output mux and the controller both use them.
- Natural sub-module: uart_tx_bit_cnt, a clearable/enabled up-counter with a terminal-count flag at DATA_WIDTH-1, instantiated once.

Test Plan:
- Reset mid-DATA: after 3 data cycles, pulse RST low -> mux_sel = 11 and busy = 0 immediately (asynchronously). After release with data_valid = 0, the block stays IDLE.
- Single frame, no parity: par_en = 0, data_valid pulsed one cycle with DATA_WIDTH = 8 -> ser_load for 1 cycle, then mux_sel sequence 00, 01×8, 11, then idle. busy is high for exactly 10 cycles and ser_en is high for exactly 8.
- Single frame, odd parity: par_en = 1, par_typ = 1 -> mux_sel sequence 00, 01×8, 10, 11. busy is high for 11 cycles and par_typ_q = 1.
- Config change mid-frame: accept with par_en = 1, then drop par_en to 0 in the second DATA cycle -> the PARITY cycle is still present and frame length stays 11.
- Back-to-back: data_valid held high for two frames without parity -> the second START directly follows the first STOP, busy never drops across 20 cycles, and ser_load pulses twice, 10 cycles apart.
